serial_deframer: RTL
====================

SERIAL_DEFRAMER -- requirements
Module: serial_deframer

Interface
REQ-001 Parameter WIDTH, default 8, data bits per frame; legal range 2..32.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 bit_en  input  1  one-cycle sample strobe; serial_in sampled only on cycles with bit_en=1.
REQ-005 serial_in  input  1  serial line, idle high, data MSB-first.
REQ-006 data_out  output  WIDTH  last accepted word, stable while data_valid=1.
REQ-007 data_valid  output  1  word available.
REQ-008 data_ready  input  1  consumer accepts; transfer on data_valid && data_ready.
REQ-009 frame_err  output  1  sticky; bad stop bit or parity.
REQ-010 overrun  output  1  sticky; good frame dropped, output buffer full.
REQ-011 clr_err  input  1  synchronous clear of frame_err and overrun.
REQ-012 busy  output  1  high in any state other than IDLE.

Function
REQ-013 States IDLE, DATA, PARITY (macro only), STOP; all state and counters hold on cycles with bit_en=0.
REQ-014 IDLE: bit_en && serial_in=0 -> DATA, bit counter cleared; serial_in=1 stays IDLE.
REQ-015 DATA: each bit_en shifts: shreg <= {shreg[WIDTH-2:0], serial_in}; counter increments; after WIDTH-th bit -> PARITY if enabled, else STOP.
REQ-016 Bit counter width $clog2(WIDTH+1); no wrap inside a frame.
REQ-017 STOP: on bit_en, serial_in=1 -> frame good; serial_in=0 -> frame_err set, word discarded; both -> IDLE.
REQ-018 Good frame, buffer free or draining same cycle: data_out <= shreg, data_valid=1 from the next cycle; latency one clk after the stop-bit sample edge.
REQ-019 Good frame while data_valid=1 and data_ready=0: new word dropped, data_out unchanged, overrun set.
REQ-020 Good frame completes in the same cycle data_valid && data_ready: new word loaded, data_valid stays 1, no overrun.
REQ-021 Handshake with no new frame: data_valid clears the cycle after data_valid && data_ready.
REQ-022 Bad frame never alters data_out or data_valid.
REQ-023 clr_err clears both sticky flags; a set event in the same cycle wins (flag stays 1).
REQ-024 A start bit is accepted on the same bit_en that ends STOP only via a new IDLE sample (no back-to-back start detection in STOP).

Reset
REQ-025 rst=1 forces state IDLE, counter 0, shreg 0, data_out 0, data_valid 0, frame_err 0, overrun 0, busy 0, immediately and asynchronously.
REQ-026 Reset mid-frame abandons the frame; first frame after release needs a fresh start bit.

Configuration
REQ-027 Macro SERIAL_DEFRAMER_PARITY_EN defined: frame = start + WIDTH data + 1 even-parity bit + stop; PARITY state samples one bit; XOR of data bits and parity bit != 0 -> frame_err set, word discarded, stop bit still consumed before IDLE.
REQ-028 Macro not defined: no PARITY state, no parity logic; frame = start + WIDTH data + stop.

Verification
REQ-029 WIDTH=8, bit_en every 4 clk, frame 0,1010_0101,1, data_ready=1 -> data_out=8'hA5, data_valid one cycle, no flags.
REQ-030 Stop bit sent as 0 for word 8'h3C -> frame_err=1, data_valid stays 0; clr_err pulse -> frame_err=0.
REQ-031 data_ready=0, frames 8'h11 then 8'h22 -> data_out=8'h11 held, overrun=1; then data_ready=1 -> 8'h11 transferred, data_valid=0.
REQ-032 data_ready asserted exactly on 8'h22 stop-sample cycle while 8'h11 pending -> 8'h11 transferred, 8'h22 loaded, overrun=0.
REQ-033 rst pulse after 4 data bits of 8'hF0, then full frame 8'h0F -> only 8'h0F delivered, flags 0.
REQ-034 With SERIAL_DEFRAMER_PARITY_EN, word 8'h07 with parity 1 -> delivered; parity 0 -> frame_err=1, no data_valid.

Source files
------------

// File: rtl/serial_deframer.sv
// Serial frame receiver: start bit, WIDTH data bits MSB-first, optional even parity, stop bit.
// Optional parity checking is built when SERIAL_DEFRAMER_PARITY_EN is defined.
module serial_deframer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             frame_err,
    output logic             overrun,
    input  logic             clr_err,
    output logic             busy
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DATA   = 2'd1,
`ifdef SERIAL_DEFRAMER_PARITY_EN
        S_PARITY = 2'd3,
`endif
        S_STOP   = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]  shreg_q, shreg_d;
    logic              good_c;
    logic              bad_c;
`ifdef SERIAL_DEFRAMER_PARITY_EN
    logic              par_bad_q, par_bad_d;
`endif

    // Frame sequencing; everything holds unless bit_en samples the line.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        good_c  = 1'b0;
        bad_c   = 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
        par_bad_d = par_bad_q;
`endif
        if (bit_en) begin
            case (state_q)
                S_IDLE: begin
                    if (!serial_in) begin
                        state_d = S_DATA;
                        cnt_d   = '0;
                    end
                end
                S_DATA: begin
                    shreg_d = {shreg_q[WIDTH-2:0], serial_in};
                    cnt_d   = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
`ifdef SERIAL_DEFRAMER_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end
`ifdef SERIAL_DEFRAMER_PARITY_EN
                S_PARITY: begin
                    par_bad_d = ^{shreg_q, serial_in};
                    state_d   = S_STOP;
                end
`endif
                S_STOP: begin
                    state_d = S_IDLE;
`ifdef SERIAL_DEFRAMER_PARITY_EN
                    if (serial_in && !par_bad_q) good_c = 1'b1;
                    else                         bad_c  = 1'b1;
`else
                    if (serial_in) good_c = 1'b1;
                    else           bad_c  = 1'b1;
`endif
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            shreg_q <= '0;
            busy    <= 1'b0;
`ifdef SERIAL_DEFRAMER_PARITY_EN
            par_bad_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            busy    <= (state_d != S_IDLE);
`ifdef SERIAL_DEFRAMER_PARITY_EN
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Single-entry output buffer with sticky error flags; a set event beats clr_err.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (good_c && (!data_valid || data_ready)) begin
                data_out   <= shreg_q;
                data_valid <= 1'b1;
            end else if (data_valid && data_ready) begin
                data_valid <= 1'b0;
            end

            if (bad_c)        frame_err <= 1'b1;
            else if (clr_err) frame_err <= 1'b0;

            if (good_c && data_valid && !data_ready) overrun <= 1'b1;
            else if (clr_err)                        overrun <= 1'b0;
        end
    end

endmodule
